// File: rtl/pipeline_ctrl_if.sv
// Hazard-controller bundle: the datapath (master) reports hazard sources,
// and the controller (slave) returns stage enables, bubbles and counters.
interface pipeline_ctrl_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
);
    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic             id_use1;
    logic             id_use2;
    logic [REG_W-1:0] ex_rd;
    logic             ex_memRead;
    logic             mem_access;
    logic             pcsrc_M;

    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             memwb_en;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             exmem_bubble;
    logic             memwb_bubble;
    logic             busy;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [CNT_W-1:0] wait_cnt;

    modport master (
        output id_rs1, id_rs2, id_use1, id_use2, ex_rd, ex_memRead, mem_access, pcsrc_M,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
        input  ifid_flush, idex_bubble, exmem_bubble, memwb_bubble,
        input  busy, stall_cnt, flush_cnt, wait_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_use1, id_use2, ex_rd, ex_memRead, mem_access, pcsrc_M,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
        output ifid_flush, idex_bubble, exmem_bubble, memwb_bubble,
        output busy, stall_cnt, flush_cnt, wait_cnt
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Stall/flush/freeze controller for the 5-stage pipeline. Priority is
// freeze > flush > load-use > normal; a small FSM times multi-cycle memory.
module pipeline_ctrl #(
    parameter int REG_W   = 5,
    parameter int MEM_LAT = 0,
    parameter int XZR_EN  = 1,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    pipeline_ctrl_if.slave   bus,
    output logic [1:0]       fsmState
);
    localparam logic [1:0] STATE_RUN     = 2'd0;
    localparam logic [1:0] STATE_WAIT    = 2'd1;
    localparam logic [1:0] STATE_RELEASE = 2'd2;

    localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'((MEM_LAT > 0) ? MEM_LAT - 1 : 0);
    localparam bit HAS_LAT = (MEM_LAT > 0);
    localparam bit SKIP_WAIT = (MEM_LAT == 1);

    logic [1:0]       state, stateNext;
    logic [LAT_W-1:0] latCnt, latCntNext;
    logic             rdIsZr, match1, match2, loadUse;
    logic             trigger, freeze, flush, stall;
    logic [CNT_W-1:0] stallCnt, flushCnt, waitCnt;

    always_comb begin
        rdIsZr  = (XZR_EN != 0) && (bus.ex_rd == '1);
        match1  = bus.id_use1 && (bus.id_rs1 == bus.ex_rd);
        match2  = bus.id_use2 && (bus.id_rs2 == bus.ex_rd);
        loadUse = bus.ex_memRead && (match1 || match2) && !rdIsZr;
        // RELEASE deliberately ignores mem_access so one access cannot re-trigger.
        trigger = HAS_LAT && (state == STATE_RUN) && bus.mem_access;
        freeze  = !reset && (trigger || (state == STATE_WAIT));
        flush   = !reset && !freeze && bus.pcsrc_M;
        stall   = !reset && !freeze && !flush && loadUse;
    end

    always_comb begin
        bus.pc_en        = !freeze && !stall;
        bus.ifid_en      = !freeze && !stall;
        bus.idex_en      = !freeze;
        bus.exmem_en     = !freeze;
        bus.memwb_en     = 1'b1;
        bus.ifid_flush   = flush;
        bus.idex_bubble  = flush || stall;
        bus.exmem_bubble = flush;
        // Frozen MEM/WB takes a bubble so the stalled access is not written back twice.
        bus.memwb_bubble = freeze;
        bus.busy         = !reset && (state != STATE_RUN);
        bus.stall_cnt    = stallCnt;
        bus.flush_cnt    = flushCnt;
        bus.wait_cnt     = waitCnt;
        fsmState         = state;
    end

    always_comb begin
        stateNext  = state;
        latCntNext = latCnt;
        case (state)
            STATE_RUN: begin
                if (trigger) begin
                    stateNext  = SKIP_WAIT ? STATE_RELEASE : STATE_WAIT;
                    latCntNext = LAT_LOAD;
                end
            end
            STATE_WAIT: begin
                latCntNext = latCnt - LAT_W'(1);
                if (latCnt == LAT_W'(1)) begin
                    stateNext = STATE_RELEASE;
                end
            end
            STATE_RELEASE: stateNext = STATE_RUN;
            default:       stateNext = STATE_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= STATE_RUN;
            latCnt   <= '0;
            stallCnt <= '0;
            flushCnt <= '0;
            waitCnt  <= '0;
        end else begin
            state  <= stateNext;
            latCnt <= latCntNext;
            if (stall && (stallCnt != '1)) stallCnt <= stallCnt + CNT_W'(1);
            if (flush && (flushCnt != '1)) flushCnt <= flushCnt + CNT_W'(1);
            if (freeze && (waitCnt != '1)) waitCnt <= waitCnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: four parametrisations share one stimulus
// stream and each is checked on the behaviour its parameters exercise.
module tb_pipeline_ctrl;
    localparam logic [8:0] NORMAL  = 9'b11111_0000;
    localparam logic [8:0] LOADUSE = 9'b00111_0100;
    localparam logic [8:0] FLUSH   = 9'b11111_1110;
    localparam logic [8:0] FREEZE  = 9'b00001_0001;
    localparam logic [1:0] S_RUN = 2'd0, S_WAIT = 2'd1, S_REL = 2'd2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    pipeline_ctrl_if #(.REG_W(5), .CNT_W(32)) ifA ();
    pipeline_ctrl_if #(.REG_W(5), .CNT_W(4))  ifB ();
    pipeline_ctrl_if #(.REG_W(5), .CNT_W(32)) ifC ();
    pipeline_ctrl_if #(.REG_W(5), .CNT_W(32)) ifD ();
    logic [1:0] stA, stB, stC, stD;

    pipeline_ctrl #(.REG_W(5), .MEM_LAT(0), .XZR_EN(1), .CNT_W(32)) dutA (.clk(clk), .reset(reset), .bus(ifA), .fsmState(stA));
    pipeline_ctrl #(.REG_W(5), .MEM_LAT(0), .XZR_EN(0), .CNT_W(4))  dutB (.clk(clk), .reset(reset), .bus(ifB), .fsmState(stB));
    pipeline_ctrl #(.REG_W(5), .MEM_LAT(3), .XZR_EN(1), .CNT_W(32)) dutC (.clk(clk), .reset(reset), .bus(ifC), .fsmState(stC));
    pipeline_ctrl #(.REG_W(5), .MEM_LAT(1), .XZR_EN(1), .CNT_W(32)) dutD (.clk(clk), .reset(reset), .bus(ifD), .fsmState(stD));

    logic [8:0] ctrlA, ctrlB, ctrlC, ctrlD;
    assign ctrlA = {ifA.pc_en, ifA.ifid_en, ifA.idex_en, ifA.exmem_en, ifA.memwb_en,
                    ifA.ifid_flush, ifA.idex_bubble, ifA.exmem_bubble, ifA.memwb_bubble};
    assign ctrlB = {ifB.pc_en, ifB.ifid_en, ifB.idex_en, ifB.exmem_en, ifB.memwb_en,
                    ifB.ifid_flush, ifB.idex_bubble, ifB.exmem_bubble, ifB.memwb_bubble};
    assign ctrlC = {ifC.pc_en, ifC.ifid_en, ifC.idex_en, ifC.exmem_en, ifC.memwb_en,
                    ifC.ifid_flush, ifC.idex_bubble, ifC.exmem_bubble, ifC.memwb_bubble};
    assign ctrlD = {ifD.pc_en, ifD.ifid_en, ifD.idex_en, ifD.exmem_en, ifD.memwb_en,
                    ifD.ifid_flush, ifD.idex_bubble, ifD.exmem_bubble, ifD.memwb_bubble};

    task automatic setIn(input logic [4:0] rs1, input logic [4:0] rs2, input logic use1,
                         input logic use2, input logic [4:0] rd, input logic memRead,
                         input logic access, input logic pcsrc);
        ifA.id_rs1 = rs1; ifA.id_rs2 = rs2; ifA.id_use1 = use1; ifA.id_use2 = use2;
        ifA.ex_rd = rd; ifA.ex_memRead = memRead; ifA.mem_access = access; ifA.pcsrc_M = pcsrc;
        ifB.id_rs1 = rs1; ifB.id_rs2 = rs2; ifB.id_use1 = use1; ifB.id_use2 = use2;
        ifB.ex_rd = rd; ifB.ex_memRead = memRead; ifB.mem_access = access; ifB.pcsrc_M = pcsrc;
        ifC.id_rs1 = rs1; ifC.id_rs2 = rs2; ifC.id_use1 = use1; ifC.id_use2 = use2;
        ifC.ex_rd = rd; ifC.ex_memRead = memRead; ifC.mem_access = access; ifC.pcsrc_M = pcsrc;
        ifD.id_rs1 = rs1; ifD.id_rs2 = rs2; ifD.id_use1 = use1; ifD.id_use2 = use2;
        ifD.ex_rd = rd; ifD.ex_memRead = memRead; ifD.mem_access = access; ifD.pcsrc_M = pcsrc;
    endtask

    task automatic idle();
        setIn(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial begin
        // Reset held while a load-use pattern is present: outputs must stay normal.
        setIn(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        chk("rst_forced_ctrl", 64'(ctrlA), 64'(NORMAL));
        chk("rst_forced_busy", 64'(ifA.busy), 64'd0);
        reset = 1'b0;
        idle();
        #1;
        chk("rst_ctrl", 64'(ctrlA), 64'(NORMAL));
        chk("rst_stall_cnt", ifA.stall_cnt, 64'd0);
        chk("rst_flush_cnt", ifA.flush_cnt, 64'd0);
        chk("rst_wait_cnt", ifC.wait_cnt, 64'd0);
        chk("rst_state", 64'(stC), 64'(S_RUN));

        // Load-use on rs1.
        setIn(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
        #1;
        chk("lu_ctrl", 64'(ctrlA), 64'(LOADUSE));
        tick();
        idle();
        #1;
        chk("lu_clear_ctrl", 64'(ctrlA), 64'(NORMAL));
        chk("lu_stall_cnt", ifA.stall_cnt, 64'd1);

        // XZR destination: suppressed with XZR_EN=1, a hazard with XZR_EN=0.
        setIn(5'd0, 5'd31, 1'b0, 1'b1, 5'd31, 1'b1, 1'b0, 1'b0);
        #1;
        chk("xzr_en1_ctrl", 64'(ctrlA), 64'(NORMAL));
        chk("xzr_en0_ctrl", 64'(ctrlB), 64'(LOADUSE));
        tick();

        // Non-hazards: operand unused, register mismatch, producer not a load.
        setIn(5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
        #1;
        chk("nouse_ctrl", 64'(ctrlA), 64'(NORMAL));
        setIn(5'd4, 5'd6, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
        #1;
        chk("nomatch_ctrl", 64'(ctrlA), 64'(NORMAL));
        setIn(5'd7, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
        #1;
        chk("noload_ctrl", 64'(ctrlA), 64'(NORMAL));
        setIn(5'd1, 5'd9, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
        #1;
        chk("lu_rs2_ctrl", 64'(ctrlA), 64'(LOADUSE));
        tick();
        idle();
        #1;
        chk("xzr_stall_cnt_a", ifA.stall_cnt, 64'd2);
        chk("xzr_stall_cnt_b", ifB.stall_cnt, 64'd3);

        // Flush with a simultaneous load-use: flush wins, no stall counted.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        setIn(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b1);
        #1;
        chk("flush_ctrl", 64'(ctrlA), 64'(FLUSH));
        tick();
        idle();
        #1;
        chk("flush_flush_cnt", ifA.flush_cnt, 64'd1);
        chk("flush_stall_cnt", ifA.stall_cnt, 64'd0);

        // MEM_LAT=3 (C) and MEM_LAT=1 (D) with mem_access held.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        setIn(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        #1;
        chk("m0_c_ctrl", 64'(ctrlC), 64'(FREEZE));
        chk("m0_c_busy", 64'(ifC.busy), 64'd0);
        chk("m0_d_ctrl", 64'(ctrlD), 64'(FREEZE));
        chk("m0_a_ctrl", 64'(ctrlA), 64'(NORMAL));
        tick();
        setIn(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        #1;
        chk("m1_c_ctrl", 64'(ctrlC), 64'(FREEZE));
        chk("m1_c_busy", 64'(ifC.busy), 64'd1);
        chk("m1_c_state", 64'(stC), 64'(S_WAIT));
        chk("m1_d_state", 64'(stD), 64'(S_REL));
        chk("m1_d_ctrl", 64'(ctrlD), 64'(FLUSH));
        chk("m1_d_busy", 64'(ifD.busy), 64'd1);
        tick();
        setIn(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        #1;
        chk("m2_c_ctrl", 64'(ctrlC), 64'(FREEZE));
        chk("m2_c_state", 64'(stC), 64'(S_WAIT));
        chk("m2_d_state", 64'(stD), 64'(S_RUN));
        chk("m2_d_ctrl", 64'(ctrlD), 64'(FREEZE));
        tick();
        #1;
        chk("m3_c_ctrl", 64'(ctrlC), 64'(NORMAL));
        chk("m3_c_state", 64'(stC), 64'(S_REL));
        chk("m3_c_busy", 64'(ifC.busy), 64'd1);
        chk("m3_c_wait_cnt", ifC.wait_cnt, 64'd3);
        tick();
        #1;
        chk("m4_c_ctrl", 64'(ctrlC), 64'(FREEZE));
        chk("m4_c_state", 64'(stC), 64'(S_RUN));
        tick();
        tick();
        tick();
        idle();
        #1;
        chk("m7_c_state", 64'(stC), 64'(S_REL));
        chk("m7_c_ctrl", 64'(ctrlC), 64'(NORMAL));
        chk("m7_c_wait_cnt", ifC.wait_cnt, 64'd6);
        tick();

        // Reset during the second WAIT cycle aborts the wait.
        setIn(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("rw_pre_state", 64'(stC), 64'(S_WAIT));
        chk("rw_forced_ctrl", 64'(ctrlC), 64'(NORMAL));
        chk("rw_forced_busy", 64'(ifC.busy), 64'd0);
        tick();
        reset = 1'b0;
        idle();
        #1;
        chk("rw_state", 64'(stC), 64'(S_RUN));
        chk("rw_ctrl", 64'(ctrlC), 64'(NORMAL));
        chk("rw_busy", 64'(ifC.busy), 64'd0);
        chk("rw_wait_cnt", ifC.wait_cnt, 64'd0);

        // 20 load-use cycles: 4-bit counter saturates at 15, 32-bit reaches 20.
        setIn(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) tick();
        idle();
        #1;
        chk("sat_stall_cnt_b", ifB.stall_cnt, 64'd15);
        chk("sat_stall_cnt_a", ifA.stall_cnt, 64'd20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Centralised stall/flush/freeze controller for the 5-stage ARMv8 pipeline. It is the parametrised successor to the separate hazard/stall logic inside the datapath. It handles three conditions:
- load-use stalls, with register-width and XZR awareness;
- taken-branch flushes resolved in MEM;
- multi-cycle data-memory accesses, using a counter-based wait FSM.

It drives per-stage enable and bubble controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB, and keeps saturating performance counters.

## Interface
Parameters:
- REG_W, 5, register-index width
- MEM_LAT, 0, extra wait cycles per data-memory access (0 = single-cycle memory, FSM never leaves RUN)
- XZR_EN, 1, when 1 the index of all ones (X31/XZR) never creates a hazard
- CNT_W, 32, performance-counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- id_rs1  in  REG_W  first source register of the instruction in ID
- id_rs2  in  REG_W  second source register in ID (after reg2loc selection)
- id_use1, id_use2  in  1 each  source operand actually read
- ex_rd  in  REG_W  destination register of the instruction in EX
- ex_memRead  in  1  EX instruction is a load
- mem_access  in  1  MEM instruction reads or writes data memory
- pcsrc_M  in  1  branch taken, resolved in MEM
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  stage register enables
- ifid_flush, idex_bubble, exmem_bubble, memwb_bubble  out  1 each  load NOP/zero controls into that register
- busy  out  1  FSM not in RUN
- stall_cnt, flush_cnt, wait_cnt  out  CNT_W each  saturating event counters

## Operation
**FSM states:** RUN, WAIT, RELEASE.
- RUN → WAIT: when mem_access=1 and MEM_LAT>0. The down-counter loads MEM_LAT-1.
- WAIT: decrement each cycle. At 0, go to RELEASE.
- RELEASE → RUN: unconditionally. In RELEASE, mem_access is ignored for triggering, so the same access cannot re-trigger.

**freeze** = (RUN and mem_access and MEM_LAT>0) or WAIT.
- All enables 0.
- memwb_en=1 and memwb_bubble=1, so no repeated writeback.
- All other bubble/flush outputs 0.
- pcsrc_M is ignored during freeze.

**loaduse** = ex_memRead and a source match on (id_use1 and id_rs1==ex_rd) or (id_use2 and id_rs2==ex_rd).
- With XZR_EN=1, a match is suppressed when ex_rd is all ones.

**Priority:** freeze > flush > loaduse > normal.
- Flush (pcsrc_M=1, no freeze): all enables 1; ifid_flush=1, idex_bubble=1, exmem_bubble=1. The three younger instructions are squashed and the PC loads the branch target.
- Load-use (no freeze/flush): pc_en=0, ifid_en=0, idex_bubble=1; other enables 1.
- Normal: all enables 1, all flush/bubble 0.

**Counters** (each saturates at all ones; never wraps):
- stall_cnt +1 per load-use cycle.
- flush_cnt +1 per flush cycle.
- wait_cnt +1 per freeze cycle.

## Timing
- All control outputs are combinational from the inputs and current state. They take effect at the next rising edge.
- Reset:
  - FSM goes to RUN, counter to 0, all perf counters to 0.
  - While reset=1, outputs are forced to normal: enables 1, flush/bubble 0, busy 0.
  - Reset asserted mid-WAIT aborts the wait. The next cycle is RUN.
- A memory access stalls the pipeline for exactly MEM_LAT cycles: MEM_LAT-1 cycles in WAIT plus the trigger cycle. The access completes in the RELEASE cycle.
- busy=1 in WAIT and RELEASE.
- A load-use hazard costs exactly 1 bubble. The next cycle, the load is in MEM and the match clears.
- Load-use together with a flush produces a flush only. The stall_cnt is not incremented.
- Back-to-back accesses: RELEASE → RUN with a new access in MEM triggers a new WAIT immediately.
- MEM_LAT=1: WAIT is never entered. Trigger cycle → RELEASE → RUN.

## Test plan
- Load-use: ex_memRead=1, ex_rd=3, id_rs1=3, id_use1=1 for one cycle → pc_en=0, ifid_en=0, idex_bubble=1; stall_cnt 0→1.
- XZR: same as load-use but ex_rd=31, id_rs2=31, id_use2=1, XZR_EN=1 → no stall. Repeat with XZR_EN=0 → stall.
- Branch flush: pcsrc_M=1 while a load-use condition is also present → ifid_flush=idex_bubble=exmem_bubble=1, all enables 1; flush_cnt=1, stall_cnt=0.
- MEM_LAT=3:
  - mem_access=1 held → freeze for 3 cycles (busy=1 from cycle 2), then RELEASE with enables 1, then RUN; wait_cnt=3.
  - A second access right after → another 3-cycle freeze.
- Reset asserted in the second WAIT cycle → next cycle RUN, all counters 0, enables 1.
- CNT_W=4: 20 load-use cycles → stall_cnt holds at 15.
